// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
package hazard_pkg;

  // Slot dest field is sized for the widest supported register index;
  // narrower indices are zero-extended on entry so compares stay exact.
  localparam int unsigned MaxRegW = 8;

  // Forward-select code meaning "read the register file".
  localparam int unsigned FWD_RF = 0;

  typedef struct packed {
    logic               v;     // slot holds a real instruction
    logic               wb;    // instruction writes back
    logic [MaxRegW-1:0] dest;  // destination register
    logic               ld;    // instruction is a load
  } slot_t;

  // Forward-select code for slot k.
  function automatic int unsigned fwd_code(input int unsigned k);
    return k + 1;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Finds the youngest in-flight writer of one source register.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SEL_W = $clog2(DEPTH + 1)
) (
  input  slot_t [DEPTH-1:0] slots,
  input  logic [MaxRegW-1:0] src,
  input  logic               en,
  output logic               hit,
  output logic [SEL_W-1:0]   idx,
  output logic               is_load
);

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (en && slots[i].v && slots[i].wb && (slots[i].dest == src)) begin
        hit     = 1'b1;
        idx     = SEL_W'(i);
        is_load = slots[i].ld;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard producing ID-stage stall and forward selects.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W  = 4,
  parameter int unsigned DEPTH  = 2,
  parameter bit          FWD_EN = 1'b1,
  localparam int unsigned SEL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             issue_wb_en,
  input  logic [REG_W-1:0] issue_dest,
  input  logic             issue_mem_read,
  input  logic             flush,
  input  logic             mem_wait,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic [SEL_W-1:0] pending_cnt
);

  slot_t [DEPTH-1:0] slot_q, slot_d;

  logic             hit1, hit2, ld1, ld2;
  logic [SEL_W-1:0] idx1, idx2;
  logic             dep_stall;

  hazard_match #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_match1 (
    .slots   (slot_q),
    .src     (MaxRegW'(src1)),
    .en      (issue_valid),
    .hit     (hit1),
    .idx     (idx1),
    .is_load (ld1)
  );

  hazard_match #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_match2 (
    .slots   (slot_q),
    .src     (MaxRegW'(src2)),
    .en      (issue_valid & two_src),
    .hit     (hit2),
    .idx     (idx2),
    .is_load (ld2)
  );

  // Dependency stall and forward selects; only a load in EXE blocks forwarding.
  always_comb begin
    dep_stall = 1'b0;
    fwd_sel1  = SEL_W'(FWD_RF);
    fwd_sel2  = SEL_W'(FWD_RF);
    if (FWD_EN) begin
      dep_stall = (hit1 && (idx1 == '0) && ld1) || (hit2 && (idx2 == '0) && ld2);
      if (hit1) fwd_sel1 = SEL_W'(fwd_code(32'(idx1)));
      if (hit2) fwd_sel2 = SEL_W'(fwd_code(32'(idx2)));
    end else begin
      dep_stall = hit1 | hit2;
    end
    // Memory wait freezes everything; a flush kills the ID instruction instead.
    stall = mem_wait | (~flush & dep_stall);
  end

  // Count in-flight writers.
  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      pending_cnt = pending_cnt + SEL_W'(slot_q[i].v & slot_q[i].wb);
    end
  end

  // Shift slots toward WB, inserting the ID instruction or a bubble at slot 0.
  always_comb begin
    slot_d = slot_q;
    if (!mem_wait) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        slot_d[i] = slot_q[i-1];
      end
      slot_d[0] = '0;
      if (issue_valid && !stall && !flush) begin
        slot_d[0].v    = 1'b1;
        slot_d[0].wb   = issue_wb_en;
        slot_d[0].dest = MaxRegW'(issue_dest);
        slot_d[0].ld   = issue_mem_read;
      end
    end
  end

  // Slot register; reset overrides mem_wait and flush.
  always_ff @(posedge clk) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: one stall-only instance and one forwarding instance share stimulus.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [3:0] src1, src2, issue_dest;
  logic       two_src, issue_wb_en, issue_mem_read, flush, mem_wait;

  logic       stall0, stall1;
  logic [1:0] fs1_0, fs2_0, pc0, fs1_1, fs2_1, pc1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_W  (4),
    .DEPTH  (2),
    .FWD_EN (1'b0)
  ) dut0 (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .src1           (src1),
    .src2           (src2),
    .two_src        (two_src),
    .issue_wb_en    (issue_wb_en),
    .issue_dest     (issue_dest),
    .issue_mem_read (issue_mem_read),
    .flush          (flush),
    .mem_wait       (mem_wait),
    .stall          (stall0),
    .fwd_sel1       (fs1_0),
    .fwd_sel2       (fs2_0),
    .pending_cnt    (pc0)
  );

  hazard_scoreboard #(
    .REG_W  (4),
    .DEPTH  (2),
    .FWD_EN (1'b1)
  ) dut1 (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .src1           (src1),
    .src2           (src2),
    .two_src        (two_src),
    .issue_wb_en    (issue_wb_en),
    .issue_dest     (issue_dest),
    .issue_mem_read (issue_mem_read),
    .flush          (flush),
    .mem_wait       (mem_wait),
    .stall          (stall1),
    .fwd_sel1       (fs1_1),
    .fwd_sel2       (fs2_1),
    .pending_cnt    (pc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic wb, input logic [3:0] d, input logic ld);
    issue_valid    = v;
    src1           = s1;
    src2           = s2;
    two_src        = two;
    issue_wb_en    = wb;
    issue_dest     = d;
    issue_mem_read = ld;
  endtask

  task automatic do_reset();
    issue(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    flush    = 1'b0;
    mem_wait = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_stall0", 32'(stall0), 0);
    check("rst_pend0", 32'(pc0), 0);
    check("rst_stall1", 32'(stall1), 0);
    check("rst_pend1", 32'(pc1), 0);
    check("rst_fs1", 32'(fs1_1), 0);
    check("rst_fs2", 32'(fs2_1), 0);

    // Stall-only: ADD R1 then SUB reading R1 stalls two cycles
    issue(1'b1, 4'd7, 4'd8, 1'b1, 1'b1, 4'd1, 1'b0);
    #1;
    check("s1_add_stall0", 32'(stall0), 0);
    tick();
    issue(1'b1, 4'd1, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0);
    #1;
    check("s1_c0_stall0", 32'(stall0), 1);
    check("s1_c0_pend0", 32'(pc0), 1);
    check("s1_c0_fs1_tied", 32'(fs1_0), 0);
    check("s1_c0_stall1", 32'(stall1), 0);
    check("s1_c0_fs1_fwd", 32'(fs1_1), 1);
    tick();
    check("s1_c1_stall0", 32'(stall0), 1);
    check("s1_c1_pend0", 32'(pc0), 1);
    tick();
    check("s1_c2_stall0", 32'(stall0), 0);
    check("s1_c2_pend0", 32'(pc0), 0);

    // Forwarding: ADD R2 then ORR R2,R2
    do_reset();
    issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
    tick();
    issue(1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 4'd10, 1'b0);
    #1;
    check("s2_b_stall1", 32'(stall1), 0);
    check("s2_b_fs1", 32'(fs1_1), 1);
    check("s2_b_fs2", 32'(fs2_1), 1);
    check("s2_b_stall0", 32'(stall0), 1);
    issue_valid = 1'b0;
    tick();
    issue(1'b1, 4'd2, 4'd2, 1'b1, 1'b1, 4'd10, 1'b0);
    #1;
    check("s2_c_fs1", 32'(fs1_1), 2);
    check("s2_c_fs2", 32'(fs2_1), 2);
    check("s2_c_stall1", 32'(stall1), 0);
    two_src = 1'b0;
    #1;
    check("s2_c_fs2_unused", 32'(fs2_1), 0);
    check("s2_c_fs1_one", 32'(fs1_1), 2);
    issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
    tick();
    tick();
    issue(1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    #1;
    check("s2_young_fs1", 32'(fs1_1), 1);
    check("s2_young_pend", 32'(pc1), 2);
    issue_valid = 1'b0;
    #1;
    check("s2_invalid_fs1", 32'(fs1_1), 0);

    // Load-use: LDR R3 then ADD R3
    do_reset();
    issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1);
    tick();
    issue(1'b1, 4'd12, 4'd3, 1'b0, 1'b1, 4'd11, 1'b0);
    #1;
    check("s3_src2_unused", 32'(stall1), 0);
    two_src = 1'b1;
    #1;
    check("s3_src2_lduse", 32'(stall1), 1);
    issue(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 4'd11, 1'b0);
    #1;
    check("s3_src1_lduse", 32'(stall1), 1);
    tick();
    check("s3_after_stall", 32'(stall1), 0);
    check("s3_after_fs1", 32'(fs1_1), 2);

    // Flush: dependent on R4 while branch resolves
    do_reset();
    issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0);
    tick();
    issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
    tick();
    issue(1'b1, 4'd4, 4'd0, 1'b0, 1'b1, 4'd13, 1'b0);
    #1;
    check("s4_noflush_stall0", 32'(stall0), 1);
    flush = 1'b1;
    #1;
    check("s4_flush_stall0", 32'(stall0), 0);
    check("s4_flush_stall1", 32'(stall1), 0);
    tick();
    flush = 1'b0;
    issue_valid = 1'b0;
    #1;
    check("s4_pend0", 32'(pc0), 1);
    check("s4_pend1", 32'(pc1), 1);
    issue(1'b1, 4'd4, 4'd0, 1'b0, 1'b1, 4'd13, 1'b0);
    #1;
    check("s4_old_slot1", 32'(fs1_1), 2);
    issue_valid = 1'b0;

    // Memory wait holds slots for three cycles, flush ignored meanwhile
    do_reset();
    issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0);
    tick();
    issue(1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 4'd14, 1'b0);
    mem_wait = 1'b1;
    for (int c = 0; c < 3; c++) begin
      flush = (c == 1);
      #1;
      check($sformatf("s5_w%0d_stall1", c), 32'(stall1), 1);
      check($sformatf("s5_w%0d_stall0", c), 32'(stall0), 1);
      check($sformatf("s5_w%0d_fs1", c), 32'(fs1_1), 1);
      check($sformatf("s5_w%0d_pend", c), 32'(pc1), 1);
      tick();
    end
    mem_wait = 1'b0;
    flush    = 1'b0;
    issue_valid = 1'b0;
    #1;
    check("s5_rel_stall1", 32'(stall1), 0);
    check("s5_rel_pend", 32'(pc1), 1);
    tick();
    issue(1'b1, 4'd5, 4'd0, 1'b0, 1'b1, 4'd14, 1'b0);
    #1;
    check("s5_adv_fs1", 32'(fs1_1), 2);
    check("s5_adv_stall0", 32'(stall0), 1);

    // Reset with full slots and mem_wait; R15 matched like any register
    do_reset();
    issue(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0);
    tick();
    issue(1'b1, 4'd15, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0);
    #1;
    check("s6_pc_fs1", 32'(fs1_1), 1);
    check("s6_pc_stall0", 32'(stall0), 1);
    tick();
    check("s6_full_pend1", 32'(pc1), 2);
    mem_wait = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    mem_wait = 1'b0;
    issue(1'b1, 4'd15, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0);
    #1;
    check("s6_pend0", 32'(pc0), 0);
    check("s6_pend1", 32'(pc1), 0);
    check("s6_stall0", 32'(stall0), 0);
    check("s6_stall1", 32'(stall1), 0);
    check("s6_fs1", 32'(fs1_1), 0);
    check("s6_fs2", 32'(fs2_1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
